alu_mult_seq: RTL and testbench

//  Multi-cycle 16x16 -> 32-bit multiply sequencer that borrows the execute-stage ALU
//  (used in ADD mode only) for shift-add multiplication, with optional signed mode.
//  It sits beside the EX stage: while alu_own=1 the top-level muxes alu_* onto the ALU

---
 rtl/alu_mult_seq.sv | 180 ++++++++++++++++++
 tb/tb_alu_mult_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/alu_mult_seq.sv
// Sequential 16x16 -> 32 multiplier that borrows the EX-stage ALU (ADD mode only)
// for operand magnitude, shift-add iterations and final two's-complement negation.
module alu_mult_seq #(
    parameter logic [2:0] OP_ADD = 3'b100,
    parameter int         N_ITER = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    input  logic [15:0] alu_out,
    input  logic        alu_cout,
    output logic [15:0] alu_A,
    output logic [15:0] alu_B,
    output logic        alu_Cin,
    output logic [2:0]  alu_Op,
    output logic        alu_invA,
    output logic        alu_invB,
    output logic        alu_sign,
    output logic        alu_own,
    output logic        busy,
    output logic        done,
    output logic [15:0] prod_hi,
    output logic [15:0] prod_lo
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABS_A,
        S_ABS_B,
        S_MUL,
        S_NEG_LO,
        S_NEG_HI,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_m;
    logic [15:0] r_p_hi;
    logic [15:0] r_p_lo;
    logic [3:0]  r_cnt;
    logic        r_signed;
    logic        r_neg;
    logic        r_c;
    logic        r_busy;
    logic        r_done;
    logic        r_own;

    logic [15:0] w_alu_a;
    logic [15:0] w_alu_b;
    logic        w_alu_cin;
    logic        w_alu_inv_a;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_m      <= '0;
            r_p_hi   <= '0;
            r_p_lo   <= '0;
            r_cnt    <= '0;
            r_signed <= 1'b0;
            r_neg    <= 1'b0;
            r_c      <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_own    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a      <= a_in;
                        r_b      <= b_in;
                        r_signed <= signed_op;
                        r_neg    <= signed_op & (a_in[15] ^ b_in[15]);
                        r_p_hi   <= '0;
                        r_p_lo   <= '0;
                        r_busy   <= 1'b1;
                        r_own    <= 1'b1;
                        r_state  <= S_ABS_A;
                    end
                end
                S_ABS_A: begin
                    r_a     <= alu_out;
                    r_state <= S_ABS_B;
                end
                S_ABS_B: begin
                    r_p_hi  <= '0;
                    r_p_lo  <= alu_out;
                    r_m     <= r_a;
                    r_cnt   <= '0;
                    r_state <= S_MUL;
                end
                S_MUL: begin
                    // Adder carry becomes the new MSB of the right-shifted partial product.
                    {r_p_hi, r_p_lo} <= {alu_cout, alu_out, r_p_lo[15:1]};
                    r_cnt            <= r_cnt + 4'd1;
                    if (r_cnt == 4'(N_ITER - 1)) begin
                        r_state <= S_NEG_LO;
                    end
                end
                S_NEG_LO: begin
                    r_p_lo  <= alu_out;
                    r_c     <= alu_cout;
                    r_state <= S_NEG_HI;
                end
                S_NEG_HI: begin
                    r_p_hi  <= alu_out;
                    r_own   <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Non-negating NEG passes are identity adds, kept so latency never depends on sign.
    always_comb begin
        w_alu_a     = '0;
        w_alu_b     = '0;
        w_alu_cin   = 1'b0;
        w_alu_inv_a = 1'b0;
        case (r_state)
            S_ABS_A: begin
                w_alu_a     = r_a;
                w_alu_inv_a = r_signed & r_a[15];
                w_alu_cin   = r_signed & r_a[15];
            end
            S_ABS_B: begin
                w_alu_a     = r_b;
                w_alu_inv_a = r_signed & r_b[15];
                w_alu_cin   = r_signed & r_b[15];
            end
            S_MUL: begin
                w_alu_a = r_p_hi;
                w_alu_b = r_p_lo[0] ? r_m : 16'h0000;
            end
            S_NEG_LO: begin
                w_alu_a     = r_p_lo;
                w_alu_inv_a = r_neg;
                w_alu_cin   = r_neg;
            end
            S_NEG_HI: begin
                w_alu_a     = r_p_hi;
                w_alu_inv_a = r_neg;
                w_alu_cin   = r_neg & r_c;
            end
            default: begin
                w_alu_a = '0;
            end
        endcase
    end

    assign alu_A    = w_alu_a;
    assign alu_B    = w_alu_b;
    assign alu_Cin  = w_alu_cin;
    assign alu_invA = w_alu_inv_a;
    assign alu_Op   = OP_ADD;
    assign alu_invB = 1'b0;
    assign alu_sign = 1'b0;
    assign alu_own  = r_own;
    assign busy     = r_busy;
    assign done     = r_done;
    assign prod_hi  = r_p_hi;
    assign prod_lo  = r_p_lo;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Directed bench for alu_mult_seq with a behavioural ADD-mode ALU closing the loop.
module tb_alu_mult_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;
    logic [15:0] alu_out;
    logic        alu_cout;
    logic [15:0] alu_A;
    logic [15:0] alu_B;
    logic        alu_Cin;
    logic [2:0]  alu_Op;
    logic        alu_invA;
    logic        alu_invB;
    logic        alu_sign;
    logic        alu_own;
    logic        busy;
    logic        done;
    logic [15:0] prod_hi;
    logic [15:0] prod_lo;

    logic [16:0] alu_sum;

    int n_checks = 0;
    int n_fail   = 0;

    alu_mult_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .signed_op(signed_op),
        .a_in     (a_in),
        .b_in     (b_in),
        .alu_out  (alu_out),
        .alu_cout (alu_cout),
        .alu_A    (alu_A),
        .alu_B    (alu_B),
        .alu_Cin  (alu_Cin),
        .alu_Op   (alu_Op),
        .alu_invA (alu_invA),
        .alu_invB (alu_invB),
        .alu_sign (alu_sign),
        .alu_own  (alu_own),
        .busy     (busy),
        .done     (done),
        .prod_hi  (prod_hi),
        .prod_lo  (prod_lo)
    );

    always #5 clk = ~clk;

    // ADD-mode ALU: Out = (invA ? ~A : A) + B + Cin, Cout = carry out of bit 15.
    assign alu_sum  = {1'b0, (alu_invA ? ~alu_A : alu_A)} + {1'b0, alu_B} + {16'd0, alu_Cin};
    assign alu_out  = alu_sum[15:0];
    assign alu_cout = alu_sum[16];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_mult(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic s, input logic [31:0] exp_prod, input bit repulse);
        int lat;
        int own_cnt;
        int bad_ctrl;
        int extra_done;
        @(negedge clk);
        a_in      = a;
        b_in      = b;
        signed_op = s;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        a_in      = 16'hDEAD;
        b_in      = 16'hBEEF;
        signed_op = ~s;
        lat       = 0;
        own_cnt   = alu_own ? 1 : 0;
        bad_ctrl  = 0;
        while (!done && lat < 40) begin
            start = (repulse && lat == 4) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
            lat++;
            if (alu_own) own_cnt++;
            if (alu_Op !== 3'b100 || alu_invB !== 1'b0 || alu_sign !== 1'b0) bad_ctrl++;
        end
        start = 1'b0;
        check_eq({name, "_latency"}, lat, 20);
        check_eq({name, "_hi"}, {16'h0, prod_hi}, {16'h0, exp_prod[31:16]});
        check_eq({name, "_lo"}, {16'h0, prod_lo}, {16'h0, exp_prod[15:0]});
        check_eq({name, "_own_cycles"}, own_cnt, 20);
        check_eq({name, "_busy_at_done"}, {31'h0, busy}, 32'h1);
        check_eq({name, "_alu_ctrl_const"}, bad_ctrl, 0);
        if (repulse) start = 1'b1;
        extra_done = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) extra_done++;
        end
        check_eq({name, "_extra_done"}, extra_done, 0);
        check_eq({name, "_busy_after"}, {31'h0, busy}, 32'h0);
        check_eq({name, "_prod_held"}, {prod_hi, prod_lo}, exp_prod);
    endtask

    initial begin
        #2;
        check_eq("rst_own", {31'h0, alu_own}, 32'h0);
        check_eq("rst_busy", {31'h0, busy}, 32'h0);
        check_eq("rst_done", {31'h0, done}, 32'h0);
        check_eq("rst_prod", {prod_hi, prod_lo}, 32'h0);
        check_eq("rst_alu_a_b", {alu_A, alu_B}, 32'h0);
        check_eq("rst_alu_op", {29'h0, alu_Op}, 32'h4);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_mult("u_3x5", 16'h0003, 16'h0005, 1'b0, 32'h0000_000F, 1'b0);
        do_mult("u_ffffxffff", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 1'b0);
        do_mult("s_m3x5", 16'hFFFD, 16'h0005, 1'b1, 32'hFFFF_FFF1, 1'b0);
        do_mult("s_8000x8000", 16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 1'b0);
        do_mult("s_8000x1", 16'h8000, 16'h0001, 1'b1, 32'hFFFF_8000, 1'b0);
        do_mult("s_0xm1", 16'h0000, 16'hFFFF, 1'b1, 32'h0000_0000, 1'b0);
        do_mult("s_m7xm9", 16'hFFF9, 16'hFFF7, 1'b1, 32'h0000_003F, 1'b0);
        do_mult("u_repulse", 16'h1234, 16'h0010, 1'b0, 32'h0001_2340, 1'b1);

        // Abort in MUL iteration 7 with an asynchronous reset.
        @(negedge clk);
        a_in      = 16'h1234;
        b_in      = 16'h5678;
        signed_op = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check_eq("pre_rst_own", {31'h0, alu_own}, 32'h1);
        rst = 1'b1;
        #1;
        check_eq("abort_own", {31'h0, alu_own}, 32'h0);
        check_eq("abort_busy", {31'h0, busy}, 32'h0);
        check_eq("abort_done", {31'h0, done}, 32'h0);
        check_eq("abort_prod", {prod_hi, prod_lo}, 32'h0);
        check_eq("abort_alu_ab", {alu_A, alu_B}, 32'h0);
        check_eq("abort_alu_cin_inv", {30'h0, alu_Cin, alu_invA}, 32'h0);
        check_eq("abort_alu_op", {29'h0, alu_Op}, 32'h4);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        begin
            int late_done;
            late_done = 0;
            for (int i = 0; i < 15; i++) begin
                @(posedge clk);
                #1;
                if (done || busy) late_done++;
            end
            check_eq("abort_no_done", late_done, 0);
        end
        do_mult("u_2x7_after_rst", 16'h0002, 16'h0007, 1'b0, 32'h0000_000E, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
